// File: rtl/alu_core.sv
// alu_core: single-cycle registered ALU, 16 operations, result and flags
// latched one clock after an accepted in_valid.
//
// Ports:
//   clk       in   1      sole clock, rising edge
//   rst       in   1      asynchronous active-high reset
//   a, b      in   WIDTH  operands (unsigned unless noted)
//   alu_sel   in   4      operation select
//   in_valid  in   1      operands/select sampled when high
//   alu_out   out  WIDTH  registered result
//   out_valid out  1      one-cycle pulse per accepted operation
//   carry     out  1      carry / borrow / shifted-out bit
//   zero      out  1      alu_out == 0 for the latest result
//   ovf       out  1      signed overflow, MUL high half nonzero,
//                         divide by zero, or unsupported op
//
// Build option: define ALU_DIV_EN to include the divider (alu_sel=3).
// Without it, alu_sel=3 reports an unsupported op (result 0, ovf=1).

module alu_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] alu_out,
    output logic             out_valid,
    output logic             carry,
    output logic             zero,
    output logic             ovf
);

    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_ROL  = 4'h6;
    localparam logic [3:0] OP_ROR  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;
    localparam logic [3:0] OP_NAND = 4'hC;
    localparam logic [3:0] OP_XNOR = 4'hD;
    localparam logic [3:0] OP_GT   = 4'hE;
    localparam logic [3:0] OP_EQ   = 4'hF;

    // Arithmetic datapath shared by the case below
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_add_ovf;
    logic               w_sub_ovf;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = a - b;
    assign w_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // Add overflows when like-signed operands give an unlike-signed sum;
    // subtract overflows when unlike-signed operands flip a's sign.
    assign w_add_ovf = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
    assign w_sub_ovf = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);

`ifdef ALU_DIV_EN
    logic             w_div_by_zero;
    logic [WIDTH-1:0] w_quot;

    assign w_div_by_zero = (b == '0);
    // Guard the divisor so the divider never sees zero
    assign w_quot = w_div_by_zero ? '1 : (a / b);
`endif

    // Next result and flags for the current inputs
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        unique case (alu_sel)
            OP_ADD: begin
                w_res   = w_sum[MSB:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = w_add_ovf;
            end
            OP_SUB: begin
                w_res   = w_diff;
                w_carry = (a < b);
                w_ovf   = w_sub_ovf;
            end
            OP_MUL: begin
                w_res = w_prod[MSB:0];
                w_ovf = |w_prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
`ifdef ALU_DIV_EN
                w_res = w_quot;
                w_ovf = w_div_by_zero;
`else
                w_res = '0;
                w_ovf = 1'b1;
`endif
            end
            OP_SHL: begin
                w_res   = {a[MSB-1:0], 1'b0};
                w_carry = a[MSB];
            end
            OP_SHR: begin
                w_res   = {1'b0, a[MSB:1]};
                w_carry = a[0];
            end
            OP_ROL: begin
                w_res   = {a[MSB-1:0], a[MSB]};
                w_carry = a[MSB];
            end
            OP_ROR: begin
                w_res   = {a[0], a[MSB:1]};
                w_carry = a[0];
            end
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_XOR:  w_res = a ^ b;
            OP_NOR:  w_res = ~(a | b);
            OP_NAND: w_res = ~(a & b);
            OP_XNOR: w_res = ~(a ^ b);
            OP_GT:   w_res = {{(WIDTH-1){1'b0}}, (a > b)};
            OP_EQ:   w_res = {{(WIDTH-1){1'b0}}, (a == b)};
        endcase
    end

    // Output registers: load on accepted input, hold otherwise
    logic [WIDTH-1:0] r_alu_out;
    logic             r_out_valid;
    logic             r_carry;
    logic             r_zero;
    logic             r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_out   <= '0;
            r_out_valid <= 1'b0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_alu_out <= w_res;
                r_carry   <= w_carry;
                r_zero    <= (w_res == '0);
                r_ovf     <= w_ovf;
            end
        end
    end

    assign alu_out   = r_alu_out;
    assign out_valid = r_out_valid;
    assign carry     = r_carry;
    assign zero      = r_zero;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: randomized stimulus against an arithmetic reference model,
// plus directed literal cases and an asynchronous mid-stream reset.

module tb_alu_core;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] alu_sel;
    logic       in_valid;
    logic [7:0] alu_out;
    logic       out_valid;
    logic       carry;
    logic       zero;
    logic       ovf;

    int n_checks = 0;
    int n_fail   = 0;

    alu_core #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .alu_sel   (alu_sel),
        .in_valid  (in_valid),
        .alu_out   (alu_out),
        .out_valid (out_valid),
        .carry     (carry),
        .zero      (zero),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operation rules
    function automatic void ref_op(input int ia, input int ib,
                                   input int sel, output int res,
                                   output int c, output int o);
        int sa, sb, s;
        sa = (ia >= 128) ? ia - 256 : ia;
        sb = (ib >= 128) ? ib - 256 : ib;
        c = 0;
        o = 0;
        res = 0;
        case (sel)
            0: begin
                res = (ia + ib) % 256;
                c = (ia + ib > 255) ? 1 : 0;
                s = sa + sb;
                o = (s > 127 || s < -128) ? 1 : 0;
            end
            1: begin
                res = (ia - ib + 256) % 256;
                c = (ia < ib) ? 1 : 0;
                s = sa - sb;
                o = (s > 127 || s < -128) ? 1 : 0;
            end
            2: begin
                res = (ia * ib) % 256;
                o = (ia * ib > 255) ? 1 : 0;
            end
            3: begin
`ifdef ALU_DIV_EN
                if (ib == 0) begin
                    res = 255;
                    o = 1;
                end else begin
                    res = ia / ib;
                end
`else
                res = 0;
                o = 1;
`endif
            end
            4: begin res = (ia * 2) % 256; c = ia / 128; end
            5: begin res = ia / 2; c = ia % 2; end
            6: begin res = (ia * 2) % 256 + ia / 128; c = ia / 128; end
            7: begin res = ia / 2 + (ia % 2) * 128; c = ia % 2; end
            8:  res = ia & ib;
            9:  res = ia | ib;
            10: res = ia ^ ib;
            11: res = 255 - (ia | ib);
            12: res = 255 - (ia & ib);
            13: res = 255 - (ia ^ ib);
            14: res = (ia > ib) ? 1 : 0;
            default: res = (ia == ib) ? 1 : 0;
        endcase
    endfunction

    // Model state: what the outputs must show right now
    int m_valid = 0;
    int m_out   = 0;
    int m_c     = 0;
    int m_z     = 0;
    int m_o     = 0;

    always @(posedge clk or posedge rst) begin
        int r, c, o;
        if (rst) begin
            m_valid = 0;
            m_out = 0;
            m_c = 0;
            m_z = 0;
            m_o = 0;
        end else if (in_valid) begin
            ref_op(int'(a), int'(b), int'(alu_sel), r, c, o);
            m_valid = 1;
            m_out = r;
            m_c = c;
            m_o = o;
            m_z = (r == 0) ? 1 : 0;
        end else begin
            m_valid = 0;
        end
    end

    function automatic logic [11:0] model_vec();
        return {m_valid[0], m_out[7:0], m_c[0], m_z[0], m_o[0]};
    endfunction

    function automatic logic [11:0] dut_vec();
        return {out_valid, alu_out, carry, zero, ovf};
    endfunction

    task automatic check(input string name, input logic [11:0] act,
                         input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got v=%b out=%h c=%b z=%b o=%b, need v=%b out=%h c=%b z=%b o=%b",
                     name, act[11], act[10:3], act[2], act[1], act[0],
                     exp[11], exp[10:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Continuous compare against the model, every cycle
    always @(negedge clk) begin
        check("model", dut_vec(), model_vec());
    end

    task automatic drive(input logic v, input logic [7:0] ia,
                         input logic [7:0] ib, input logic [3:0] sel);
        in_valid = v;
        a = ia;
        b = ib;
        alu_sel = sel;
    endtask

    // One op, then pin both DUT and model to a hand-computed result
    task automatic directed(input string name, input logic [7:0] ia,
                            input logic [7:0] ib, input logic [3:0] sel,
                            input logic [7:0] eo, input logic ec,
                            input logic ez, input logic eov);
        logic [11:0] exp;
        drive(1'b1, ia, ib, sel);
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00, 4'h0);
        exp = {1'b1, eo, ec, ez, eov};
        check(name, dut_vec(), exp);
        check({name, "_model"}, model_vec(), exp);
    endtask

    logic [7:0] corner [4];
    logic [7:0] ra, rb;

    initial begin
        corner[0] = 8'h00;
        corner[1] = 8'hFF;
        corner[2] = 8'h7F;
        corner[3] = 8'h80;

        rst = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 4'h0);
        #1;
        check("reset_state", dut_vec(), 12'h000);

        // in_valid during reset must be ignored
        drive(1'b1, 8'h12, 8'h34, 4'h0);
        @(negedge clk);
        check("valid_in_reset", dut_vec(), 12'h000);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 4'h0);
        @(negedge clk);

        directed("add_ovf",  8'h7F, 8'h01, 4'h0, 8'h80, 1'b0, 1'b0, 1'b1);
        directed("sub_brw",  8'h00, 8'h01, 4'h1, 8'hFF, 1'b1, 1'b0, 1'b0);
        directed("sub_zero", 8'h55, 8'h55, 4'h1, 8'h00, 1'b0, 1'b1, 1'b0);
        directed("mul_ovf",  8'h10, 8'h10, 4'h2, 8'h00, 1'b0, 1'b1, 1'b1);
        directed("rol",      8'h81, 8'h00, 4'h6, 8'h03, 1'b1, 1'b0, 1'b0);
`ifdef ALU_DIV_EN
        directed("div",      8'h64, 8'h07, 4'h3, 8'h0E, 1'b0, 1'b0, 1'b0);
        directed("div_zero", 8'h64, 8'h00, 4'h3, 8'hFF, 1'b0, 1'b0, 1'b1);
`else
        directed("div_unsup", 8'h64, 8'h07, 4'h3, 8'h00, 1'b0, 1'b1, 1'b1);
`endif
        directed("gt",       8'h80, 8'h7F, 4'hE, 8'h01, 1'b0, 1'b0, 1'b0);
        directed("eq",       8'h3C, 8'h3C, 4'hF, 8'h01, 1'b0, 1'b0, 1'b0);
        directed("nand",     8'hFF, 8'h0F, 4'hC, 8'hF0, 1'b0, 1'b0, 1'b0);
        directed("shr",      8'h01, 8'h00, 4'h5, 8'h00, 1'b1, 1'b1, 1'b0);

        // Idle cycle: result held, out_valid low
        @(negedge clk);
        check("hold", dut_vec(), {1'b0, 8'h00, 1'b1, 1'b1, 1'b0});

        // Three back-to-back ops, reset lands while the third is pending
        drive(1'b1, 8'h03, 8'h04, 4'h0);
        @(negedge clk);
        check("b2b_1", dut_vec(), {1'b1, 8'h07, 1'b0, 1'b0, 1'b0});
        drive(1'b1, 8'hF0, 8'h20, 4'h0);
        @(negedge clk);
        check("b2b_2", dut_vec(), {1'b1, 8'h10, 1'b1, 1'b0, 1'b0});
        drive(1'b1, 8'h09, 8'h03, 4'h2);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", dut_vec(), 12'h000);
        @(negedge clk);
        check("rst_no_pulse", dut_vec(), 12'h000);
        rst = 1'b0;
        drive(1'b1, 8'h06, 8'h07, 4'h2);
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00, 4'h0);
        check("post_rst", dut_vec(), {1'b1, 8'h2A, 1'b0, 1'b0, 1'b0});

        // Randomized traffic, biased toward corner operands
        for (int i = 0; i < 400; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 3) == 0) ra = corner[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) rb = corner[$urandom_range(0, 3)];
            if ($urandom_range(0, 7) == 0) rb = ra;
            drive(($urandom_range(0, 3) != 0), ra, rb,
                  4'($urandom_range(0, 15)));
            @(negedge clk);
        end

        drive(1'b0, 8'h00, 8'h00, 4'h0);
        @(negedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
